// File: rtl/iso14443a_pkg.sv
// rtl/iso14443a_pkg.sv - shared ISO 14443A types, constants and CRC_A byte step
package iso14443a_pkg;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_REQA,
        KIND_WUPA,
        KIND_SHORT,
        KIND_HLTA,
        KIND_STD_CRC,
        KIND_NO_CRC,
        KIND_ERROR
    } frame_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IN_FRAME,
        ST_PARTIAL
    } rx_state_t;

    localparam logic [15:0] CRC_A_INIT      = 16'h6363;
    localparam logic [15:0] CRC_A_POLY_REFL = 16'h8408;
    localparam logic [7:0]  CMD_REQA        = 8'h26;
    localparam logic [7:0]  CMD_WUPA        = 8'h52;
    localparam logic [7:0]  CMD_HLTA        = 8'h50;

    // One byte of CRC_A, LSB first, eight bit steps unrolled.
    function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_A_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_a.sv
// rtl/crc_a.sv - registered CRC_A accumulator, one byte per enable
module crc_a
    import iso14443a_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_A_INIT;
        end else if (init) begin
            crc_q <= CRC_A_INIT;
        end else if (en) begin
            crc_q <= crc_a_byte(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_frame_classifier.sv
// rtl/rx_frame_classifier.sv - per-frame summary of the rx byte stream for the init/anticollision FSM
module rx_frame_classifier
    import iso14443a_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    localparam int CW = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          soc,
    input  logic          eoc,
    input  logic [7:0]    data,
    input  logic [2:0]    data_bits,
    input  logic          data_valid,
    input  logic          sequence_error,
    input  logic          parity_error,
    output logic          frame_done,
    output logic [2:0]    frame_kind,
    output logic [CW-1:0] frame_bytes,
    output logic [2:0]    frame_last_bits,
    output logic [7:0]    frame_byte0,
    output logic [7:0]    frame_byte1,
    output logic          crc_ok
);

    rx_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]  last_q, last_d;
    logic [7:0]  byte0_q, byte0_d, byte1_q, byte1_d;
    logic        err_q, err_d;

    logic [15:0] crc;
    logic [15:0] crc_fin;
    logic        in_frame, full_byte, crc_en, report;
    logic        crc_ok_d;
    frame_kind_t kind_d;

    logic          frame_done_q;
    frame_kind_t   frame_kind_q;
    logic [CW-1:0] frame_bytes_q;
    logic [2:0]    frame_last_bits_q;
    logic [7:0]    frame_byte0_q, frame_byte1_q;
    logic          crc_ok_q;

    assign in_frame  = (state_q != ST_IDLE);
    assign full_byte = (data_bits == 3'd0);
    assign crc_en    = (state_q == ST_IN_FRAME) && data_valid && full_byte;
    assign report    = in_frame && eoc && !soc;

    crc_a u_crc_a (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (soc),
        .en    (crc_en),
        .data  (data),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            last_q  <= '0;
            byte0_q <= '0;
            byte1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            byte0_q <= byte0_d;
            byte1_q <= byte1_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (soc) state_d = ST_IN_FRAME;
            end
            ST_IN_FRAME: begin
                if (soc)                             state_d = ST_IN_FRAME;
                else if (eoc)                        state_d = ST_IDLE;
                else if (data_valid && !full_byte)   state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (soc)      state_d = ST_IN_FRAME;
                else if (eoc) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame accumulators; a soc in any state restarts them, discarding the old frame.
    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        byte0_d = byte0_q;
        byte1_d = byte1_q;
        err_d   = err_q;
        if (soc) begin
            count_d = '0;
            last_d  = '0;
            byte0_d = '0;
            byte1_d = '0;
            err_d   = 1'b0;
        end else if (in_frame) begin
            if (sequence_error || parity_error) err_d = 1'b1;
            if (data_valid) begin
                if (state_q == ST_PARTIAL) begin
                    err_d = 1'b1;
                end else begin
                    if (count_q == CW'(0))      byte0_d = data;
                    else if (count_q == CW'(1)) byte1_d = data;
                    if (!full_byte)                         last_d = data_bits;
                    else if (count_q == CW'(MAX_BYTES))     err_d = 1'b1;
                    else                                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    // Summary is built from next-state values so a byte arriving with eoc is included.
    always_comb begin
        crc_fin  = crc_en ? crc_a_byte(crc, data) : crc;
        crc_ok_d = (crc_fin == 16'h0000) && (count_d >= CW'(3)) && (last_d == 3'd0);
        kind_d   = KIND_NO_CRC;
        if (err_d || (count_d == CW'(0) && last_d == 3'd0)) begin
            kind_d = KIND_ERROR;
        end else if (count_d == CW'(0) && last_d == 3'd7) begin
            if (byte0_d == CMD_REQA)      kind_d = KIND_REQA;
            else if (byte0_d == CMD_WUPA) kind_d = KIND_WUPA;
            else                          kind_d = KIND_SHORT;
        end else if (crc_ok_d && count_d == CW'(4) && byte0_d == CMD_HLTA && byte1_d == 8'h00) begin
            kind_d = KIND_HLTA;
        end else if (crc_ok_d) begin
            kind_d = KIND_STD_CRC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q      <= 1'b0;
            frame_kind_q      <= KIND_NONE;
            frame_bytes_q     <= '0;
            frame_last_bits_q <= '0;
            frame_byte0_q     <= '0;
            frame_byte1_q     <= '0;
            crc_ok_q          <= 1'b0;
        end else begin
            frame_done_q <= report;
            if (report) begin
                frame_kind_q      <= kind_d;
                frame_bytes_q     <= count_d;
                frame_last_bits_q <= last_d;
                frame_byte0_q     <= byte0_d;
                frame_byte1_q     <= byte1_d;
                crc_ok_q          <= crc_ok_d;
            end
        end
    end

    assign frame_done      = frame_done_q;
    assign frame_kind      = frame_kind_q;
    assign frame_bytes     = frame_bytes_q;
    assign frame_last_bits = frame_last_bits_q;
    assign frame_byte0     = frame_byte0_q;
    assign frame_byte1     = frame_byte1_q;
    assign crc_ok          = crc_ok_q;

endmodule

// File: doc/rx_frame_classifier.md
Name: rx_frame_classifier

Overview:
- Sits directly downstream of `rx` in the ISO 14443A core and consumes its soc/eoc/data stream.
- Tracks each received PCD frame: counts bytes, captures the first two bytes, runs CRC_A over every full byte and tracks the error flags.
- At end of frame it emits one registered summary (frame kind, lengths, CRC status).
- The future initialisation/anticollision FSM acts only on this summary, never on the raw byte stream.

Parameters:
- MAX_BYTES, 64, maximum full bytes per frame; must be ≥ 4. A frame with more bytes is an error frame.

Ports:
- clk  input  1  13.56MHz recovered carrier clock; stops during pauses
- rst_n  input  1  asynchronous active-low reset; connected to the synchronised reset at top level
- soc  input  1  start of frame pulse, from rx
- eoc  input  1  end of frame pulse, from rx
- data  input  8  received byte, LSB first on air, from rx
- data_bits  input  3  valid bits in data; 0 means 8 (full byte), 1..7 means partial byte in the LSBs
- data_valid  input  1  data/data_bits strobe
- sequence_error  input  1  pulse, from rx
- parity_error  input  1  pulse, from rx
- frame_done  output  1  one-cycle pulse; summary outputs are updated in the same cycle
- frame_kind  output  3  frame_kind_t, defined in the package
- frame_bytes  output  $clog2(MAX_BYTES+1)  count of full bytes
- frame_last_bits  output  3  bit count of the trailing partial byte; 0 means none
- frame_byte0  output  8  first byte received (full or partial)
- frame_byte1  output  8  second byte received
- crc_ok  output  1  CRC_A residue is zero and frame_bytes ≥ 3 and frame_last_bits == 0

Behaviour:
- Reset: FSM enters IDLE. frame_done=0, frame_kind=KIND_NONE, all other outputs 0, internal counters and flags cleared.
- FSM states:
  - IDLE: ignores data_valid, eoc and error pulses. soc → IN_FRAME; clears count, error flag and byte captures; loads CRC with 0x6363.
  - IN_FRAME:
    - data_valid with data_bits==0: count++, byte captured if index <2, CRC updated.
    - data_valid with data_bits≠0: partial byte stored as frame_last_bits, captured like a full byte, CRC not updated; → PARTIAL.
    - eoc → IDLE and report.
  - PARTIAL: any further data_valid sets the error flag. eoc → IDLE and report.
- soc while IN_FRAME or PARTIAL: the current frame is discarded without a report and a new frame restarts.
- data_valid and eoc in the same cycle: the data is included, then the frame is reported.
- sequence_error or parity_error while in a frame sets a sticky error flag. An error pulse coinciding with eoc counts.
- Byte count saturates at MAX_BYTES. A further full byte sets the error flag.
- CRC_A definition: reflected polynomial 0x8408, init 0x6363, LSB first, no final XOR. It processes one byte per data_valid, 8 unrolled steps combinationally, result registered.
  - A valid frame (data followed by its CRC, LSB byte first) leaves residue 0x0000.
- Report: frame_done is asserted one cycle after eoc is sampled. Latency: eoc at cycle N → frame_done at N+1. Summary outputs hold until the next report.
- Classification, first match wins:
  1. Error flag set, or empty frame (no data at all) → KIND_ERROR.
  2. frame_bytes==0 and last_bits==7: byte0 0x26 → KIND_REQA; byte0 0x52 → KIND_WUPA; otherwise KIND_SHORT.
  3. crc_ok and frame_bytes==4 and byte0==0x50 and byte1==0x00 → KIND_HLTA.
  4. crc_ok → KIND_STD_CRC.
  5. Otherwise → KIND_NO_CRC. This covers anticollision frames and frames with a bad CRC; crc_ok=0.
- Reset mid-frame: everything returns to reset values immediately and no report is made.

Decomposition:
- Package iso14443a_pkg:
  - frame_kind_t enum: NONE, REQA, WUPA, SHORT, HLTA, STD_CRC, NO_CRC, ERROR.
  - Constants: CRC_A_INIT=16'h6363, CRC_A_POLY_REFL=16'h8408, CMD_REQA=8'h26, CMD_WUPA=8'h52, CMD_HLTA=8'h50.
- Sub-module crc_a:
  - Ports: clk, rst_n, init, en, data[7:0], crc[15:0].
  - Sequential. Shared with the future Tx path, which appends CRCs.

Test Plan:
- REQA: soc; 0x26 with data_bits=7; eoc → frame_done at eoc+1, KIND_REQA, bytes=0, last_bits=7, byte0=0x26, crc_ok=0. Repeat with 0x52 → KIND_WUPA; with 0x35 → KIND_SHORT.
- HLTA: 0x50 0x00 0x57 0xCD, full bytes → KIND_HLTA, bytes=4, crc_ok=1. Same with 0xCC as last byte → KIND_NO_CRC, crc_ok=0.
- Anticollision: 0x93 0x20 → KIND_NO_CRC, bytes=2, byte0=0x93, byte1=0x20. Then 0x93 0x20 0x12 with data_bits=4 → bytes=2, last_bits=4, KIND_NO_CRC. Then a full byte after the partial byte → KIND_ERROR.
- Errors: parity_error pulse mid-frame of 0x50 0x00 0x57 0xCD → KIND_ERROR. soc immediately followed by eoc → KIND_ERROR. MAX_BYTES+1 bytes → KIND_ERROR with bytes=MAX_BYTES.
- Boundaries:
  - data_valid on the same cycle as eoc → byte counted.
  - soc mid-frame → no report for the first frame; the second frame reports correctly.
  - rst_n low mid-frame → no frame_done, all outputs 0.
  - eoc or data_valid while IDLE → no frame_done.
